// File: rtl/serial_pair_adder.sv
// Digit-serial adder: a two-bit slice is added per cycle, LSB pair first, with a registered carry.
// Operands arrive and the result leaves through valid/ready handshakes.
module serial_pair_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned SLICES = WIDTH / 2;
  localparam int unsigned IW     = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SLICES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [2:0]       slice_sum;
  logic [IW:0]      shamt;

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign s         = s_q;
  assign cout      = cout_q;

  // Operand registers shift right two bits per slice, so the active pair is always at [1:0].
  assign slice_sum = 3'(a_q[1:0]) + 3'(b_q[1:0]) + 3'(carry_q);
  assign shamt     = {idx_q, 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          s_d     = '0;
          cout_d  = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        // s was cleared on accept and each slice is written once, so OR-in is a plain write.
        s_d     = s_q | (WIDTH'(slice_sum[1:0]) << shamt);
        carry_d = slice_sum[2];
        idx_d   = idx_q + IW'(1);
        a_d     = a_q >> 2;
        b_d     = b_q >> 2;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_sum[2];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
